// File: rtl/audio_sample_buffer.sv
// Record/playback sample buffer between the AC97 front end and block RAM.
// Optional macro LOOP_PLAY_EN: playback wraps to the first sample instead of returning to IDLE.
module audio_sample_buffer #(
  parameter int ADDR_W = 12
) (
  input  logic              clock_100mhz,
  input  logic              reset_b,
  input  logic              ready,
  input  logic [7:0]        audio_in_data,
  output logic [7:0]        audio_out_data,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   length,
  output logic              full
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RECORD = 2'b01,
    ST_PLAY   = 2'b10
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [ADDR_W:0]   length_r;
  logic              full_r;
  logic [7:0]        mem_r [0:DEPTH-1];
  logic [7:0]        rd_data_r;
  logic              rd_pend_r;
  logic [7:0]        audio_out_r;

  logic              start_rec_s;
  logic              start_play_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic              last_rd_s;
  logic              fill_s;
  logic              abort_play_s;
  logic [7:0]        audio_nxt_s;

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_nxt_s  = state_r;
    start_rec_s  = 1'b0;
    start_play_s = 1'b0;
    wr_en_s      = 1'b0;
    rd_en_s      = 1'b0;
    fill_s       = 1'b0;
    abort_play_s = 1'b0;
    last_rd_s    = ({1'b0, rd_addr_r} == (length_r - {{ADDR_W{1'b0}}, 1'b1}));
    case (state_r)
      ST_IDLE: begin
        if (rec_start) begin
          state_nxt_s = ST_RECORD;
          start_rec_s = 1'b1;
        end else if (play_start && (length_r != {(ADDR_W+1){1'b0}})) begin
          state_nxt_s  = ST_PLAY;
          start_play_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RECORD: begin
        wr_en_s = ready;
        fill_s  = ready && (length_r == (DEPTH_L - {{ADDR_W{1'b0}}, 1'b1}));
        if (stop || fill_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RECORD;
        end
      end
      ST_PLAY: begin
        // A stop coinciding with ready abandons that read as well
        rd_en_s = ready && !stop;
        if (stop) begin
          abort_play_s = 1'b1;
          state_nxt_s  = ST_IDLE;
        end else if (rd_en_s && last_rd_s) begin
`ifdef LOOP_PLAY_EN
          state_nxt_s = ST_PLAY;
`else
          state_nxt_s = ST_IDLE;
`endif
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Playback output: silence on abort/record entry, pending read lands, otherwise silence outside PLAY
  always_comb begin
    audio_nxt_s = audio_out_r;
    if (abort_play_s || start_rec_s) begin
      audio_nxt_s = 8'h00;
    end else if (rd_pend_r) begin
      audio_nxt_s = rd_data_r;
    end else if (state_nxt_s != ST_PLAY) begin
      audio_nxt_s = 8'h00;
    end else begin
      audio_nxt_s = audio_out_r;
    end
  end

  // State register
  always_ff @(posedge clock_100mhz or negedge reset_b) begin
    if (!reset_b) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Addresses, length/full bookkeeping, read pipeline and playback register
  always_ff @(posedge clock_100mhz or negedge reset_b) begin
    if (!reset_b) begin
      wr_addr_r   <= {ADDR_W{1'b0}};
      rd_addr_r   <= {ADDR_W{1'b0}};
      length_r    <= {(ADDR_W+1){1'b0}};
      full_r      <= 1'b0;
      rd_pend_r   <= 1'b0;
      audio_out_r <= 8'h00;
    end else begin
      if (start_rec_s) begin
        wr_addr_r <= {ADDR_W{1'b0}};
        length_r  <= {(ADDR_W+1){1'b0}};
        full_r    <= 1'b0;
      end else if (wr_en_s) begin
        wr_addr_r <= wr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        length_r  <= length_r + {{ADDR_W{1'b0}}, 1'b1};
        if (fill_s) begin
          full_r <= 1'b1;
        end
      end
      if (start_play_s) begin
        rd_addr_r <= {ADDR_W{1'b0}};
      end else if (rd_en_s) begin
        rd_addr_r <= last_rd_s ? {ADDR_W{1'b0}} : (rd_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1});
      end
      rd_pend_r   <= rd_en_s;
      audio_out_r <= audio_nxt_s;
    end
  end

  // Sample storage: no reset so it maps onto block RAM
  always_ff @(posedge clock_100mhz) begin
    if (wr_en_s) begin
      mem_r[wr_addr_r] <= audio_in_data;
    end
    if (rd_en_s) begin
      rd_data_r <= mem_r[rd_addr_r];
    end
  end

  assign state          = state_r;
  assign length         = length_r;
  assign full           = full_r;
  assign audio_out_data = audio_out_r;

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Directed bench for audio_sample_buffer: a default-size and an 8-deep instance share stimulus.
module tb_audio_sample_buffer;

  logic        clock_100mhz = 1'b0;
  logic        reset_b = 1'b1;
  logic        ready = 1'b0;
  logic [7:0]  audio_in_data = 8'h00;
  logic        rec_start = 1'b0;
  logic        play_start = 1'b0;
  logic        stop = 1'b0;

  logic [7:0]  b_out, s_out;
  logic [1:0]  b_state, s_state;
  logic [12:0] b_length;
  logic [3:0]  s_length;
  logic        b_full, s_full;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic       r;
    logic [7:0] d;
    logic       rs;
    logic       ps;
    logic       sp;
    logic [1:0] st;
    logic [3:0] len;
    logic       fl;
    logic [7:0] out;
  } vec_t;

  vec_t tv[$];

  always #5 clock_100mhz = ~clock_100mhz;

  audio_sample_buffer dut_big (
    .clock_100mhz(clock_100mhz), .reset_b(reset_b), .ready(ready),
    .audio_in_data(audio_in_data), .audio_out_data(b_out),
    .rec_start(rec_start), .play_start(play_start), .stop(stop),
    .state(b_state), .length(b_length), .full(b_full)
  );

  audio_sample_buffer #(.ADDR_W(3)) dut_small (
    .clock_100mhz(clock_100mhz), .reset_b(reset_b), .ready(ready),
    .audio_in_data(audio_in_data), .audio_out_data(s_out),
    .rec_start(rec_start), .play_start(play_start), .stop(stop),
    .state(s_state), .length(s_length), .full(s_full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; pulses drop right after the consuming edge
  task automatic cyc(input logic r, input logic [7:0] d, input logic rs, input logic ps, input logic sp);
    ready = r; audio_in_data = d; rec_start = rs; play_start = ps; stop = sp;
    @(posedge clock_100mhz);
    #1;
    ready = 1'b0; audio_in_data = 8'h00; rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
  endtask

  task automatic chk_both(input string name, input logic [1:0] st, input logic [3:0] len,
                          input logic fl, input logic [7:0] out);
    chk({name, ".s_state"}, 32'(s_state), 32'(st));
    chk({name, ".s_length"}, 32'(s_length), 32'(len));
    chk({name, ".s_full"}, 32'(s_full), 32'(fl));
    chk({name, ".s_out"}, 32'(s_out), 32'(out));
    chk({name, ".b_state"}, 32'(b_state), 32'(st));
    chk({name, ".b_length"}, 32'(b_length), 32'(len));
    chk({name, ".b_full"}, 32'(b_full), 32'(fl));
    chk({name, ".b_out"}, 32'(b_out), 32'(out));
  endtask

  initial begin
    // record 01..05 with a gap, stop, then play back
    tv.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b01, 4'd0, 1'b0, 8'h00});
    tv.push_back('{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 2'b01, 4'd1, 1'b0, 8'h00});
    tv.push_back('{1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 2'b01, 4'd1, 1'b0, 8'h00});
    tv.push_back('{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 2'b01, 4'd2, 1'b0, 8'h00});
    tv.push_back('{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 2'b01, 4'd3, 1'b0, 8'h00});
    tv.push_back('{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 2'b01, 4'd4, 1'b0, 8'h00});
    tv.push_back('{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 2'b01, 4'd5, 1'b0, 8'h00});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 4'd5, 1'b0, 8'h00});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'b10, 4'd5, 1'b0, 8'h00});
    tv.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10, 4'd5, 1'b0, 8'h00});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10, 4'd5, 1'b0, 8'h01});
    tv.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10, 4'd5, 1'b0, 8'h01});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10, 4'd5, 1'b0, 8'h02});
    tv.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10, 4'd5, 1'b0, 8'h02});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10, 4'd5, 1'b0, 8'h03});
    tv.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10, 4'd5, 1'b0, 8'h03});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10, 4'd5, 1'b0, 8'h04});
`ifdef LOOP_PLAY_EN
    tv.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10, 4'd5, 1'b0, 8'h04});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10, 4'd5, 1'b0, 8'h05});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10, 4'd5, 1'b0, 8'h05});
    tv.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10, 4'd5, 1'b0, 8'h05});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10, 4'd5, 1'b0, 8'h01});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 4'd5, 1'b0, 8'h00});
`else
    tv.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 4'd5, 1'b0, 8'h00});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 4'd5, 1'b0, 8'h05});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 4'd5, 1'b0, 8'h00});
    tv.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 4'd5, 1'b0, 8'h00});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 4'd5, 1'b0, 8'h00});
    tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 4'd5, 1'b0, 8'h00});
`endif

    // reset state
    #2 reset_b = 1'b0;
    #1 chk_both("reset", 2'b00, 4'd0, 1'b0, 8'h00);
    @(posedge clock_100mhz);
    #1 reset_b = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].r, tv[i].d, tv[i].rs, tv[i].ps, tv[i].sp);
      chk_both($sformatf("vec%0d", i), tv[i].st, tv[i].len, tv[i].fl, tv[i].out);
    end

    // stop coinciding with ready: sample stored and counted
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk_both("rec2", 2'b01, 4'd0, 1'b0, 8'h00);
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h7F, 1'b0, 1'b0, 1'b1);
    chk_both("stop_ready", 2'b00, 4'd2, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("play2_s0", 32'(s_out), 32'h11);
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("play2_s1", 32'(s_out), 32'h7F);
    chk("play2_b1", 32'(b_out), 32'h7F);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_both("play2_end", 2'b00, 4'd2, 1'b0, 8'h00);

    // asynchronous reset mid-PLAY with nonzero output
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_both("pre_reset", 2'b10, 4'd2, 1'b0, 8'h11);
    #2 reset_b = 1'b0;
    #1 chk_both("async_reset", 2'b00, 4'd0, 1'b0, 8'h00);
    @(posedge clock_100mhz);
    #1 reset_b = 1'b1;

    // IDLE with length 0: stop and play_start ignored, rec_start wins over play_start
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_both("idle_stop", 2'b00, 4'd0, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk_both("play_empty", 2'b00, 4'd0, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk_both("rec_wins", 2'b01, 4'd0, 1'b0, 8'h00);

    // fill the 8-deep instance; the large one keeps recording
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
      if (i == 8) begin
        chk("fill8_state", 32'(s_state), 32'h0);
        chk("fill8_len", 32'(s_length), 32'd8);
        chk("fill8_full", 32'(s_full), 32'h1);
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    chk("fill_s_len", 32'(s_length), 32'd8);
    chk("fill_s_full", 32'(s_full), 32'h1);
    chk("fill_s_state", 32'(s_state), 32'h0);
    chk("fill_b_len", 32'(b_length), 32'd10);
    chk("fill_b_full", 32'(b_full), 32'h0);
    chk("fill_b_state", 32'(b_state), 32'h1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("fill_play_s", 32'(s_out), 32'h21);
    chk("fill_play_b", 32'(b_out), 32'h00);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("rerec_full", 32'(s_full), 32'h0);
    chk("rerec_len", 32'(s_length), 32'd0);
    chk("rerec_state", 32'(s_state), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_buffer.md
AUDIO_SAMPLE_BUFFER -- requirements
Module: audio_sample_buffer

Interface
REQ-001 Parameter ADDR_W, default 12, sets the sample-address width; buffer depth DEPTH = 2^ADDR_W samples of 8 bits.
REQ-002 clock_100mhz  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset_b  input  1  asynchronous active-low reset.
REQ-004 ready  input  1  one-cycle sample strobe from the AC97 front end, at most one per 48 kHz frame.
REQ-005 audio_in_data  input  8  signed captured sample, valid on the ready cycle.
REQ-006 audio_out_data  output  8  signed playback sample, registered, held between updates.
REQ-007 rec_start  input  1  single-cycle pulse that begins recording.
REQ-008 play_start  input  1  single-cycle pulse that begins playback.
REQ-009 stop  input  1  single-cycle pulse that aborts recording or playback.
REQ-010 state  output  2  00 IDLE, 01 RECORD, 10 PLAY; 11 is never driven.
REQ-011 length  output  ADDR_W+1  number of valid recorded samples, 0..DEPTH.
REQ-012 full  output  1  high when the last recording ended because the buffer filled.

Function
REQ-013 Storage: internal DEPTH x 8 array with synchronous write and synchronous read, inferable as block RAM, with no reset on the array contents.
REQ-014 IDLE, rec_start: go to RECORD next cycle; write address := 0; length := 0; full := 0.
REQ-015 IDLE, play_start with length != 0: go to PLAY; read address := 0.
REQ-016 IDLE, play_start with length == 0: stay in IDLE.
REQ-017 IDLE, rec_start and play_start in the same cycle: rec_start wins.
REQ-018 IDLE, stop: no effect.
REQ-019 RECORD, each ready: mem[write address] := audio_in_data; write address increments; length increments in the same cycle.
REQ-020 RECORD, no ready: no write occurs.
REQ-021 RECORD, length reaches DEPTH: go to IDLE on the cycle after the final write; full := 1; write address wraps to 0 but is unused.
REQ-022 RECORD, stop: go to IDLE; if stop coincides with ready, that sample is written and counted first.
REQ-023 RECORD, rec_start and play_start: ignored.
REQ-024 PLAY, each ready: read mem[read address]; audio_out_data takes that value exactly 2 cycles after the ready cycle; read address increments.
REQ-025 The 2-cycle update in REQ-024 is always stable well before the next strobe, so the downstream latch-on-ready captures the previous sample.
REQ-026 PLAY, ready that consumes sample length-1: end-of-buffer behaviour is per REQ-035.
REQ-027 PLAY, stop: go to IDLE next cycle and abandon any pending read.
REQ-028 PLAY, rec_start and play_start: ignored.
REQ-029 On every entry to IDLE or RECORD, audio_out_data := 8'h00 (silence) on the entry cycle; it stays 0 outside PLAY.
REQ-030 stop takes priority over an end-of-buffer transition in the same cycle; the result is IDLE.
REQ-031 length and full are retained across PLAY and IDLE and change only per REQ-014, REQ-019 and REQ-021.

Reset
REQ-032 While reset_b is low, asynchronously: state = IDLE; length = 0; full = 0; audio_out_data = 8'h00; read and write addresses = 0; pending-read pipeline cleared.
REQ-033 Reset asserted mid-RECORD or mid-PLAY aborts immediately; no write occurs during reset.
REQ-034 Reset release is not required to be synchronised in this block; the first transition is allowed on the first clock_100mhz edge with reset_b high.

Configuration
REQ-035 Macro LOOP_PLAY_EN.
- Defined: after sample length-1 is consumed, the read address wraps to 0 and PLAY continues until stop.
- Undefined: after sample length-1 is consumed, the block goes to IDLE the cycle after that ready; the last sample is still output, then audio_out_data returns to 0 per REQ-029.

Verification
REQ-036 Reset, rec_start, 5 ready pulses with data 01,02,03,04,05, then stop -> state 00, length 5, full 0.
REQ-037 After REQ-036, play_start, then 5 ready pulses -> audio_out_data 01..05, each 2 cycles after its ready.
- LOOP_PLAY_EN undefined: state 00 after the 5th pulse.
- LOOP_PLAY_EN defined: a 6th ready gives 01 and state stays 10.
REQ-038 ADDR_W=3, rec_start, 10 ready pulses -> length 8, full 1, state 00 after the 8th; pulses 9 and 10 ignored.
REQ-039 In RECORD, stop and ready in the same cycle with data 7F -> sample stored, length incremented, state 00.
REQ-040 In IDLE with length 0, play_start -> state stays 00; rec_start and play_start together -> state 01.
REQ-041 Mid-PLAY with audio_out_data nonzero, reset_b low for 1 cycle -> state 00, length 0, full 0, audio_out_data 00 immediately, without waiting for a clock edge.
